// File: rtl/cla_pkg.sv
// Shared definitions for the carry-look-ahead adder.
// - CLA_WIDTH / CLA_GROUP : default operand width and lookahead group size.
// - LA_MAX                : widest lookahead span the helper supports.
// - lookahead()           : carry into position i+1 as a flat sum of products
//                           of generate/propagate terms, no chained carries.
package cla_pkg;

  localparam int CLA_WIDTH = 4;
  localparam int CLA_GROUP = 4;
  localparam int LA_MAX    = 64;
  localparam int LA_IW     = $clog2(LA_MAX);

  // c[i+1] = c0&p[0]&..&p[i] | g[0]&p[1]&..&p[i] | ... | g[i].
  // Each product term is built independently, so the result is a two-level
  // AND-OR of the inputs rather than a ripple through lower carries.
  function automatic logic lookahead(input logic [LA_MAX-1:0] p,
                                     input logic [LA_MAX-1:0] g,
                                     input logic              c0,
                                     input int                i);
    logic res;
    logic prod;
    res = 1'b0;
    for (int k = -1; k <= i; k++) begin
      if (k < 0) prod = c0;
      else       prod = g[LA_IW'(k)];
      for (int m = k + 1; m <= i; m++) prod = prod & p[LA_IW'(m)];
      res = res | prod;
    end
    return res;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit lookahead slice.
// Ports:
//   a, b : operand bits of this slice
//   ci   : carry into the slice (from the second-level lookahead)
//   s    : slice sum bits
//   pg   : slice propagate (AND of all bit propagates)
//   gg   : slice generate (carry out of the slice when ci = 0)
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             pg,
  output logic             gg
);

  logic [GROUP-1:0]  p;
  logic [GROUP-1:0]  g;
  logic [GROUP-1:0]  c;
  logic [LA_MAX-1:0] pw;
  logic [LA_MAX-1:0] gw;

  assign p = a ^ b;
  assign g = a & b;

  // Group P/G depend only on a and b; keeping them apart from the carry
  // block keeps the top-level carry path free of false loops.
  always_comb begin
    pw = '0;
    gw = '0;
    pw[GROUP-1:0] = p;
    gw[GROUP-1:0] = g;
    pg = &p;
    gg = lookahead(pw, gw, 1'b0, GROUP - 1);
  end

  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP - 1; i++) c[i+1] = lookahead(pw, gw, ci, i);
    s = p ^ c;
  end

endmodule

// File: rtl/cla.sv
// Carry-look-ahead adder: s = ain + bin + cin with two-level lookahead.
// Ports:
//   clk, rst     : clock (rising edge) and asynchronous active-high reset
//   ain, bin     : unsigned operands
//   cin          : carry in
//   s, cout      : combinational sum (mod 2^WIDTH) and carry out
//   pg, gg       : combinational whole-word propagate / generate
//   s_q, cout_q  : s and cout registered one cycle, cleared by rst
module cla
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             pg,
  output logic             gg,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_bad_width
    $error("cla: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
  end
  if (GROUP > LA_MAX || NG > LA_MAX) begin : g_bad_span
    $error("cla: lookahead span exceeds %0d", LA_MAX);
  end

  logic [NG-1:0]     gp;
  logic [NG-1:0]     ggv;
  logic [NG:0]       gc;
  logic [LA_MAX-1:0] pw;
  logic [LA_MAX-1:0] gw;

  for (genvar k = 0; k < NG; k++) begin : g_slice
    cla_group #(.GROUP(GROUP)) u_grp (
      .a  (ain[k*GROUP +: GROUP]),
      .b  (bin[k*GROUP +: GROUP]),
      .ci (gc[k]),
      .s  (s[k*GROUP +: GROUP]),
      .pg (gp[k]),
      .gg (ggv[k])
    );
  end

  // Second-level lookahead over the slice P/G terms.
  always_comb begin
    pw = '0;
    gw = '0;
    pw[NG-1:0] = gp;
    gw[NG-1:0] = ggv;
    pg = &gp;
    gg = lookahead(pw, gw, 1'b0, NG - 1);
  end

  always_comb begin
    gc    = '0;
    gc[0] = cin;
    for (int i = 0; i < NG; i++) gc[i+1] = lookahead(pw, gw, cin, i);
  end

  assign cout = gc[NG];

  // Stage p1: registered copy of the combinational result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_cla.sv
module tb_cla;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ain, bin;
  logic        cin;
  logic [3:0]  s, s_q;
  logic        cout, pg, gg, cout_q;

  logic [15:0] a16, b16, s16, s16_q;
  logic        c16, cout16, pg16, gg16, cout16_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla #(.WIDTH(4), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .ain(ain), .bin(bin), .cin(cin),
    .s(s), .cout(cout), .pg(pg), .gg(gg), .s_q(s_q), .cout_q(cout_q)
  );

  cla #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst(rst), .ain(a16), .bin(b16), .cin(c16),
    .s(s16), .cout(cout16), .pg(pg16), .gg(gg16), .s_q(s16_q), .cout_q(cout16_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
    ain = a; bin = b; cin = c;
    #1;
  endtask

  initial begin
    logic [4:0]  sum5;
    logic [16:0] sum17;
    logic [15:0] x, y;
    logic        z;

    rst = 1'b1;
    a16 = '0; b16 = '0; c16 = 1'b0;
    drive4(4'd4, 4'd7, 1'b1);
    check("reset_s_q", 32'(s_q), 32'h0);
    check("reset_cout_q", 32'(cout_q), 32'h0);
    check("reset_s_follows", 32'(s), 32'hC);

    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("c1_s", 32'(s), 32'hC);
    check("c1_cout", 32'(cout), 32'h0);
    check("c1_s_q", 32'(s_q), 32'hC);
    check("c1_cout_q", 32'(cout_q), 32'h0);

    // Reset between edges clears the register at once; s keeps following.
    @(negedge clk) rst = 1'b1;
    #1;
    check("mid_rst_s_q", 32'(s_q), 32'h0);
    check("mid_rst_cout_q", 32'(cout_q), 32'h0);
    check("mid_rst_s", 32'(s), 32'hC);
    @(posedge clk) #1;
    check("held_rst_s_q", 32'(s_q), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    check("reload_s_q", 32'(s_q), 32'hC);

    drive4(4'd5, 4'd2, 1'b0);
    check("c2_s", 32'(s), 32'h7);
    check("c2_cout", 32'(cout), 32'h0);

    drive4(4'd8, 4'd5, 1'b1);
    check("c3_s", 32'(s), 32'hE);
    check("c3_cout", 32'(cout), 32'h0);

    @(negedge clk);
    drive4(4'd15, 4'd1, 1'b0);
    check("c4_s", 32'(s), 32'h0);
    check("c4_cout", 32'(cout), 32'h1);
    check("c4_pg", 32'(pg), 32'h0);
    check("c4_gg", 32'(gg), 32'h1);
    @(posedge clk) #1;
    check("c4_s_q", 32'(s_q), 32'h0);
    check("c4_cout_q", 32'(cout_q), 32'h1);

    drive4(4'd15, 4'd15, 1'b1);
    check("max_s", 32'(s), 32'hF);
    check("max_cout", 32'(cout), 32'h1);

    drive4(4'd10, 4'd5, 1'b1);
    check("prop_pg", 32'(pg), 32'h1);
    check("prop_gg", 32'(gg), 32'h0);
    check("prop_s", 32'(s), 32'h0);
    check("prop_cout", 32'(cout), 32'h1);

    // Exhaustive sweep of the 4-bit adder.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          drive4(4'(a), 4'(b), 1'(c));
          sum5 = 5'(a) + 5'(b) + 5'(c);
          check("sweep_s", 32'(s), 32'(sum5[3:0]));
          check("sweep_cout", 32'(cout), 32'(sum5[4]));
          check("sweep_pg", 32'(pg), 32'(&(ain ^ bin)));
          check("sweep_gg", 32'(gg), 32'((5'(a) + 5'(b)) >> 4));
        end
      end
    end

    // 16-bit, four groups: corners then random operands.
    for (int n = 0; n < 202; n++) begin
      if (n == 0)      begin x = 16'hFFFF; y = 16'hFFFF; z = 1'b1; end
      else if (n == 1) begin x = 16'hAAAA; y = 16'h5555; z = 1'b1; end
      else begin
        x = 16'($urandom);
        y = 16'($urandom);
        z = 1'($urandom);
      end
      a16 = x; b16 = y; c16 = z;
      #1;
      sum17 = 17'(x) + 17'(y) + 17'(z);
      check("w16_s", 32'(s16), 32'(sum17[15:0]));
      check("w16_cout", 32'(cout16), 32'(sum17[16]));
      check("w16_pg", 32'(pg16), 32'(&(x ^ y)));
      check("w16_gg", 32'(gg16), 32'((17'(x) + 17'(y)) >> 16));
    end

    @(negedge clk);
    a16 = 16'hAAAA; b16 = 16'h5555; c16 = 1'b1;
    @(posedge clk) #1;
    check("w16_s_q", 32'(s16_q), 32'h0);
    check("w16_cout_q", 32'(cout16_q), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
